// File: rtl/intersection_sequencer.sv
// Two-road intersection sequencer with one pedestrian crossing: a prescaler tick drives a
// timed phase FSM, the button is synchronised and edge-detected, lamps decode the phase.
module intersection_sequencer #(
    parameter int unsigned COUNT_TO    = 25_000_000,
    parameter logic [7:0]  T_GREEN     = 8'd10,
    parameter logic [7:0]  T_GREEN_MIN = 8'd4,
    parameter logic [7:0]  T_YELLOW    = 8'd3,
    parameter logic [7:0]  T_ALLRED    = 8'd1,
    parameter logic [7:0]  T_WALK      = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buton,
    output logic       pulse,
    output logic       rosu_a,
    output logic       galben_a,
    output logic       verde_a,
    output logic       rosu_b,
    output logic       galben_b,
    output logic       verde_b,
    output logic       walk,
    output logic       ped_wait,
    output logic [7:0] remaining,
    output logic [2:0] state
);

    localparam int unsigned      CNT_W     = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COUNT_TO - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(COUNT_TO - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       CUT_LIMIT = T_GREEN - T_GREEN_MIN + 8'd1;
    localparam logic             DIR_A     = 1'b0;
    localparam logic             DIR_B     = 1'b1;

    typedef enum logic [2:0] {
        ST_A_GRN = 3'd0,
        ST_A_YEL = 3'd1,
        ST_AR_A  = 3'd2,
        ST_B_GRN = 3'd3,
        ST_B_YEL = 3'd4,
        ST_AR_B  = 3'd5,
        ST_WALK  = 3'd6
    } phase_t;

    logic [CNT_W-1:0] count_r;
    logic             pulse_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             fall_s;
    logic             req_r;
    logic             next_dir_r;
    phase_t           state_r;
    phase_t           next_state_s;
    logic [7:0]       remaining_r;
    logic             cut_s;
    logic             advance_s;
    logic             enter_walk_s;
    logic [6:0]       lamps_r;

    function automatic logic [7:0] phase_duration(input phase_t ph);
        case (ph)
            ST_A_GRN, ST_B_GRN: phase_duration = T_GREEN;
            ST_A_YEL, ST_B_YEL: phase_duration = T_YELLOW;
            ST_WALK:            phase_duration = T_WALK;
            default:            phase_duration = T_ALLRED;
        endcase
    endfunction

    // Prescaler; pulse is registered one count early so it is high exactly while count is last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            pulse_r <= 1'b0;
        end else begin
            if (count_r == CNT_LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
            pulse_r <= (count_r == CNT_PRE);
        end
    end

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
        end else begin
            sync1_r <= buton;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign fall_s = sync3_r & ~sync2_r;

    // Pending request: WALK entry wins over a coincident edge, edges inside WALK are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_r <= 1'b0;
        end else if (enter_walk_s) begin
            req_r <= 1'b0;
        end else if (fall_s && (state_r != ST_WALK)) begin
            req_r <= 1'b1;
        end else begin
            req_r <= req_r;
        end
    end

    // Successor phase and whether this tick ends the current phase.
    always_comb begin
        next_state_s = ST_AR_B;
        case (state_r)
            ST_A_GRN: next_state_s = ST_A_YEL;
            ST_A_YEL: next_state_s = ST_AR_A;
            ST_AR_A:  next_state_s = req_r ? ST_WALK : ST_B_GRN;
            ST_B_GRN: next_state_s = ST_B_YEL;
            ST_B_YEL: next_state_s = ST_AR_B;
            ST_AR_B:  next_state_s = req_r ? ST_WALK : ST_A_GRN;
            ST_WALK:  next_state_s = (next_dir_r == DIR_A) ? ST_A_GRN : ST_B_GRN;
            default:  next_state_s = ST_AR_B;
        endcase
        cut_s = ((state_r == ST_A_GRN) || (state_r == ST_B_GRN)) && req_r &&
                (remaining_r <= CUT_LIMIT);
        advance_s    = pulse_r && ((remaining_r <= 8'd1) || cut_s);
        enter_walk_s = advance_s && (next_state_s == ST_WALK);
    end

    // Phase register with its countdown and the direction to resume after WALK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_AR_B;
            remaining_r <= T_ALLRED;
            next_dir_r  <= DIR_A;
        end else if (advance_s) begin
            state_r     <= next_state_s;
            remaining_r <= phase_duration(next_state_s);
            if (next_state_s == ST_WALK) begin
                next_dir_r <= (state_r == ST_AR_A) ? DIR_B : DIR_A;
            end else begin
                next_dir_r <= next_dir_r;
            end
        end else if (pulse_r && (remaining_r > 8'd1)) begin
            remaining_r <= remaining_r - 8'd1;
        end else begin
            remaining_r <= remaining_r;
        end
    end

    // Lamp decode, order {rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b, walk}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamps_r <= 7'b100_100_0;
        end else begin
            case (state_r)
                ST_A_GRN: lamps_r <= 7'b001_100_0;
                ST_A_YEL: lamps_r <= 7'b010_100_0;
                ST_B_GRN: lamps_r <= 7'b100_001_0;
                ST_B_YEL: lamps_r <= 7'b100_010_0;
                ST_WALK:  lamps_r <= 7'b100_100_1;
                default:  lamps_r <= 7'b100_100_0;
            endcase
        end
    end

    assign pulse     = pulse_r;
    assign rosu_a    = lamps_r[6];
    assign galben_a  = lamps_r[5];
    assign verde_a   = lamps_r[4];
    assign rosu_b    = lamps_r[3];
    assign galben_b  = lamps_r[2];
    assign verde_b   = lamps_r[1];
    assign walk      = lamps_r[0];
    assign ped_wait  = req_r;
    assign remaining = remaining_r;
    assign state     = state_r;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Scoreboard bench for intersection_sequencer with a 4-cycle tick: expected phase/countdown
// entries are queued per scenario and compared at every pulse.
module tb_intersection_sequencer;

    localparam int CT = 4;
    localparam logic [2:0] A_GRN = 3'd0;
    localparam logic [2:0] A_YEL = 3'd1;
    localparam logic [2:0] AR_A  = 3'd2;
    localparam logic [2:0] B_GRN = 3'd3;
    localparam logic [2:0] B_YEL = 3'd4;
    localparam logic [2:0] AR_B  = 3'd5;
    localparam logic [2:0] WALK  = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] rem;
        logic       pw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       buton;
    logic       pulse;
    logic       rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b, walk, ped_wait;
    logic [7:0] remaining;
    logic [2:0] state;
    logic [6:0] lamps_s;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_pulse_cyc = 0;
    int   acc = 0;
    bit   first_pulse = 1'b1;

    intersection_sequencer #(.COUNT_TO(CT)) dut (
        .clk(clk), .rst(rst), .buton(buton), .pulse(pulse),
        .rosu_a(rosu_a), .galben_a(galben_a), .verde_a(verde_a),
        .rosu_b(rosu_b), .galben_b(galben_b), .verde_b(verde_b),
        .walk(walk), .ped_wait(ped_wait), .remaining(remaining), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign lamps_s = {rosu_a, galben_a, verde_a, rosu_b, galben_b, verde_b, walk};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] lamp_exp(input logic [2:0] st);
        logic a_go;
        logic b_go;
        a_go = (st == A_GRN) || (st == A_YEL);
        b_go = (st == B_GRN) || (st == B_YEL);
        return {!a_go, st == A_YEL, st == A_GRN, !b_go, st == B_YEL, st == B_GRN, st == WALK};
    endfunction

    task automatic push_phase(input logic [2:0] st, input int hi, input int lo, input logic pw);
        exp_t e;
        for (int r = hi; r >= lo; r--) begin
            e.st  = st;
            e.rem = 8'(r);
            e.pw  = pw;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_ticks(input int n);
        exp_t e;
        logic ok;
        for (int k = 0; k < n; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 4 * CT; i++) begin
                @(negedge clk);
                if (pulse === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_val("pulse_seen", 32'(ok), 32'd1);
            if (ok) begin
                if (!first_pulse) begin
                    check_val("tick_period", cyc - last_pulse_cyc, CT);
                    acc += cyc - last_pulse_cyc;
                end
                first_pulse    = 1'b0;
                last_pulse_cyc = cyc;
                check_val("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("state", 32'(state), 32'(e.st));
                    check_val("remaining", 32'(remaining), 32'(e.rem));
                    check_val("ped_wait", 32'(ped_wait), 32'(e.pw));
                    check_val("lamps", 32'(lamps_s), 32'(lamp_exp(e.st)));
                end
            end
        end
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        first_pulse = 1'b1;
        sb_q.delete();
    endtask

    task automatic press(input int hold);
        buton = 1'b0;
        fork
            begin
                repeat (hold) @(negedge clk);
                buton = 1'b1;
            end
        join_none
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_state"}, 32'(state), 32'(AR_B));
        check_val({tag, "_remaining"}, 32'(remaining), 32'd1);
        check_val({tag, "_pulse"}, 32'(pulse), 32'd0);
        check_val({tag, "_lamps"}, 32'(lamps_s), 32'(7'b100_100_0));
        check_val({tag, "_ped_wait"}, 32'(ped_wait), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        buton = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Free-running cycle, no button; 28 ticks from A_GRN start to the next.
        restart();
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 10, 1'b0);
        run_ticks(2);
        acc = 0;
        push_phase(A_GRN, 9, 1, 1'b0);
        push_phase(A_YEL, 3, 1, 1'b0);
        push_phase(AR_A, 1, 1, 1'b0);
        push_phase(B_GRN, 10, 1, 1'b0);
        push_phase(B_YEL, 3, 1, 1'b0);
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 10, 1'b0);
        run_ticks(28);
        check_val("period_clk", acc, 32'd112);

        // Early press in A_GRN: green held to the minimum, then cut short.
        restart();
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 10, 1'b0);
        run_ticks(2);
        press(6);
        push_phase(A_GRN, 9, 7, 1'b1);
        push_phase(A_YEL, 3, 1, 1'b1);
        push_phase(AR_A, 1, 1, 1'b1);
        push_phase(WALK, 8, 1, 1'b0);
        push_phase(B_GRN, 10, 10, 1'b0);
        run_ticks(16);

        // Late press in A_GRN, then presses on WALK entry and inside WALK are dropped.
        restart();
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 3, 1'b0);
        run_ticks(9);
        press(6);
        push_phase(A_GRN, 2, 2, 1'b1);
        push_phase(A_YEL, 3, 1, 1'b1);
        run_ticks(4);
        repeat (2) @(negedge clk);
        press(20);
        push_phase(AR_A, 1, 1, 1'b1);
        push_phase(WALK, 8, 5, 1'b0);
        run_ticks(5);
        buton = 1'b1;
        repeat (3) @(negedge clk);
        press(4);
        push_phase(WALK, 4, 1, 1'b0);
        push_phase(B_GRN, 10, 1, 1'b0);
        push_phase(B_YEL, 3, 1, 1'b0);
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 10, 1'b0);
        run_ticks(19);

        // Press in B_GRN held 50 clk: one WALK, resume on A, no second WALK.
        restart();
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 1, 1'b0);
        push_phase(A_YEL, 3, 1, 1'b0);
        push_phase(AR_A, 1, 1, 1'b0);
        push_phase(B_GRN, 10, 10, 1'b0);
        run_ticks(16);
        press(50);
        push_phase(B_GRN, 9, 7, 1'b1);
        push_phase(B_YEL, 3, 1, 1'b1);
        push_phase(AR_B, 1, 1, 1'b1);
        push_phase(WALK, 8, 1, 1'b0);
        push_phase(A_GRN, 10, 1, 1'b0);
        push_phase(A_YEL, 3, 1, 1'b0);
        push_phase(AR_A, 1, 1, 1'b0);
        push_phase(B_GRN, 10, 10, 1'b0);
        run_ticks(30);

        // Asynchronous reset on the pulse cycle of B_YEL remaining=2, then restart.
        restart();
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 1, 1'b0);
        push_phase(A_YEL, 3, 1, 1'b0);
        push_phase(AR_A, 1, 1, 1'b0);
        push_phase(B_GRN, 10, 1, 1'b0);
        push_phase(B_YEL, 3, 3, 1'b0);
        run_ticks(26);
        repeat (4) @(negedge clk);
        check_val("pre_rst_pulse", 32'(pulse), 32'd1);
        check_val("pre_rst_remaining", 32'(remaining), 32'd2);
        check_val("pre_rst_lamps", 32'(lamps_s), 32'(7'b100_010_0));
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        first_pulse = 1'b1;
        push_phase(AR_B, 1, 1, 1'b0);
        push_phase(A_GRN, 10, 1, 1'b0);
        push_phase(A_YEL, 3, 3, 1'b0);
        run_ticks(12);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
